db_read_addr_gen: RTL and testbench
===================================

Name: db_read_addr_gen

Overview:
- Affine read-address generator sitting directly upstream of the double-buffered memory_core read port; drives its addr_in/ren_in.
- Walks a loop nest of up to 6 dimensions (stride/range per dimension, base starting_addr) and issues one address per accepted handshake.
- Stops after iter_cnt addresses. One run is started per bank switch.

Parameters:
- NUM_DIMS, 6, number of loop dimensions supported.
- ADDR_W, 16, address width; arithmetic is modulo 2^ADDR_W.
- RANGE_W, 32, width of each range field.
- CNT_W, 32, width of iter_cnt and the issued-address counter.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- clk_en  input  1  global enable; when 0, all state holds and no handshake completes.
- flush  input  1  synchronous abort; returns the block to IDLE.
- start  input  1  single-cycle pulse that begins a run; honoured only in IDLE.
- dimensionality  input  4  number of active dimensions, 0..NUM_DIMS; values above NUM_DIMS are clamped.
- starting_addr  input  ADDR_W  base address.
- strides  input  NUM_DIMS*ADDR_W  packed stride_i at [i*ADDR_W +: ADDR_W].
- ranges  input  NUM_DIMS*RANGE_W  packed range_i at [i*RANGE_W +: RANGE_W].
- iter_cnt  input  CNT_W  number of addresses to issue per run.
- addr_rdy  input  1  consumer accepts the current address (ren side).
- addr_out  output  ADDR_W  current address.
- addr_valid  output  1  addr_out is valid.
- last  output  1  current address is the final one of the run.
- busy  output  1  high in RUN.
- done  output  1  one-cycle pulse after the final transfer.

Behaviour:
- Reset (reset=0, async): state=IDLE; all idx_i, off_i and issued cleared. Outputs: addr_out=0, addr_valid=0, last=0, busy=0, done=0.
- Configuration inputs are sampled at the start cycle. They must remain static for the whole run; the block does not re-register them.
- FSM states:
  - IDLE: on start & clk_en, go to RUN if iter_cnt!=0, else go to DONE.
  - RUN: addr_valid=1. A transfer occurs when addr_valid & addr_rdy & clk_en. On the transfer with last=1, go to DONE.
  - DONE: done=1 for exactly one clk_en cycle, then go to IDLE.
- addr_out = starting_addr + sum over active i of off_i, truncated to ADDR_W. Inactive dimensions (i >= dimensionality) contribute 0 and never count.
- off_i tracks idx_i*stride_i incrementally; there is no multiplier.
- Effective range: a range_i of 0 is treated as 1.
- Per transfer, dimensions step as an odometer:
  - Dimension 0 increments (idx_0+1, off_0+=stride_0).
  - If idx_0 reaches range_0-1 before the step, it wraps: idx_0=0, off_0=0, and the carry passes to dimension 1, and so on upward.
  - A carry out of the top active dimension wraps every dimension to 0, so addresses repeat circularly. The run continues.
- issued increments on each transfer. last = (issued == iter_cnt-1) while in RUN.
- Latency:
  - First address is valid the cycle after start.
  - Next address is valid the cycle after each transfer; sustained throughput is 1 address/cycle when addr_rdy=1.
- Backpressure: while addr_rdy=0, addr_out and last hold stable. addr_valid never drops in RUN before the final transfer.
- start while in RUN or DONE is ignored.
- flush (with clk_en) in any state: go to IDLE, clear counters, force addr_valid=0. No done pulse. flush has priority over start in the same cycle.
- Reset mid-run: immediate return to reset values; no done pulse.
- Single-address run (iter_cnt=1): last=1 on the first valid cycle.

Test Plan:
- dimensionality=3, strides 1/3/9, ranges 3/3/3, base 0, iter_cnt=27, addr_rdy=1 -> addresses 0..26 on consecutive cycles; last on 26; done one cycle later.
- dimensionality=2, strides 2/16, ranges 4/2, base 0x100, iter_cnt=8 -> 0x100,0x102,0x104,0x106,0x110,0x112,0x114,0x116.
- dimensionality=1, stride 1, range 2, iter_cnt=5 -> 0,1,0,1,0 (circular wrap); last on the 5th address.
- Sequence of case 1 with addr_rdy toggled pseudo-randomly and clk_en held low for 3 cycles -> same address sequence; outputs stable while stalled.
- flush asserted after 4 transfers, then start -> addr_valid drops the next cycle, no done pulse; the restarted run begins again at 0.
- iter_cnt=0 with start -> addr_valid never rises; done pulses the cycle after start. Also: reset low mid-run -> outputs return to 0 asynchronously.

Source files
------------

// File: rtl/db_read_addr_gen.sv
// ============================================================================
// Module      : db_read_addr_gen
// Description : Affine read-address generator for the double-buffered memory
//               core read port. Walks an odometer-style loop nest of up to
//               NUM_DIMS dimensions and issues iter_cnt addresses per run.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module db_read_addr_gen #(
    parameter int NUM_DIMS = 6,
    parameter int ADDR_W   = 16,
    parameter int RANGE_W  = 32,
    parameter int CNT_W    = 32
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         clk_en_i,
    input  logic                         flush_i,
    input  logic                         start_i,
    input  logic [3:0]                   dimensionality_i,
    input  logic [ADDR_W-1:0]            starting_addr_i,
    input  logic [NUM_DIMS*ADDR_W-1:0]   strides_i,
    input  logic [NUM_DIMS*RANGE_W-1:0]  ranges_i,
    input  logic [CNT_W-1:0]             iter_cnt_i,
    input  logic                         addr_rdy_i,
    output logic [ADDR_W-1:0]            addr_out_o,
    output logic                         addr_valid_o,
    output logic                         last_o,
    output logic                         busy_o,
    output logic                         done_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [RANGE_W-1:0]  idx_q [NUM_DIMS];
    logic [RANGE_W-1:0]  idx_d [NUM_DIMS];
    logic [ADDR_W-1:0]   off_q [NUM_DIMS];
    logic [ADDR_W-1:0]   off_d [NUM_DIMS];
    logic [CNT_W-1:0]    issued_q, issued_d;

    logic [3:0]          dims_eff;
    logic [ADDR_W-1:0]   addr_sum;
    logic                last_w;
    logic                carry;

    // Clamp the active dimension count to what the hardware supports.
    assign dims_eff = (dimensionality_i > 4'(NUM_DIMS)) ? 4'(NUM_DIMS) : dimensionality_i;

    // Current address: base plus the running offsets of the active dimensions.
    always_comb begin
        addr_sum = starting_addr_i;
        for (int i = 0; i < NUM_DIMS; i++) begin
            if (i < int'(dims_eff)) begin
                addr_sum = addr_sum + off_q[i];
            end
        end
    end

    assign last_w       = (state_q == S_RUN) && (issued_q == (iter_cnt_i - CNT_W'(1)));
    assign addr_out_o   = (state_q == S_RUN) ? addr_sum : '0;
    assign addr_valid_o = (state_q == S_RUN);
    assign last_o       = last_w;
    assign busy_o       = (state_q == S_RUN);
    assign done_o       = (state_q == S_DONE);

    // Next-state logic: FSM transitions plus odometer stepping on each transfer.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        off_d    = off_q;
        issued_d = issued_q;
        carry    = 1'b1;

        unique case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d  = (iter_cnt_i != '0) ? S_RUN : S_DONE;
                    issued_d = '0;
                    for (int i = 0; i < NUM_DIMS; i++) begin
                        idx_d[i] = '0;
                        off_d[i] = '0;
                    end
                end
            end
            S_RUN: begin
                if (addr_rdy_i) begin
                    if (last_w) begin
                        state_d  = S_DONE;
                        issued_d = '0;
                        for (int i = 0; i < NUM_DIMS; i++) begin
                            idx_d[i] = '0;
                            off_d[i] = '0;
                        end
                    end else begin
                        issued_d = issued_q + CNT_W'(1);
                        // Odometer: a wrapped dimension passes its carry upward;
                        // a carry out of the top one leaves everything at zero.
                        for (int i = 0; i < NUM_DIMS; i++) begin
                            if ((i < int'(dims_eff)) && carry) begin
                                if (idx_q[i] >= (((ranges_i[i*RANGE_W +: RANGE_W] == '0) ?
                                                  RANGE_W'(1) : ranges_i[i*RANGE_W +: RANGE_W])
                                                 - RANGE_W'(1))) begin
                                    idx_d[i] = '0;
                                    off_d[i] = '0;
                                end else begin
                                    idx_d[i] = idx_q[i] + RANGE_W'(1);
                                    off_d[i] = off_q[i] + strides_i[i*ADDR_W +: ADDR_W];
                                    carry    = 1'b0;
                                end
                            end
                        end
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Abort wins over everything, including a same-cycle start.
        if (flush_i) begin
            state_d  = S_IDLE;
            issued_d = '0;
            for (int i = 0; i < NUM_DIMS; i++) begin
                idx_d[i] = '0;
                off_d[i] = '0;
            end
        end
    end

    // State registers; everything holds while the global enable is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            issued_q <= '0;
            for (int i = 0; i < NUM_DIMS; i++) begin
                idx_q[i] <= '0;
                off_q[i] <= '0;
            end
        end else if (clk_en_i) begin
            state_q  <= state_d;
            issued_q <= issued_d;
            for (int i = 0; i < NUM_DIMS; i++) begin
                idx_q[i] <= idx_d[i];
                off_q[i] <= off_d[i];
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_db_read_addr_gen.sv
`default_nettype none

module tb_db_read_addr_gen;

    logic         clk;
    logic         rst_n;
    logic         clk_en;
    logic         flush;
    logic         start;
    logic [3:0]   dims;
    logic [15:0]  base;
    logic [95:0]  strides;
    logic [191:0] ranges;
    logic [31:0]  iter;
    logic         rdy;
    logic [15:0]  addr;
    logic         valid;
    logic         last;
    logic         busy;
    logic         done;

    int pass_cnt;
    int total_cnt;

    db_read_addr_gen dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .clk_en_i         (clk_en),
        .flush_i          (flush),
        .start_i          (start),
        .dimensionality_i (dims),
        .starting_addr_i  (base),
        .strides_i        (strides),
        .ranges_i         (ranges),
        .iter_cnt_i       (iter),
        .addr_rdy_i       (rdy),
        .addr_out_o       (addr),
        .addr_valid_o     (valid),
        .last_o           (last),
        .busy_o           (busy),
        .done_o           (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg(input logic [3:0] d, input logic [15:0] b,
                       input logic [15:0] s0, input logic [15:0] s1, input logic [15:0] s2,
                       input logic [31:0] r0, input logic [31:0] r1, input logic [31:0] r2,
                       input logic [31:0] it);
        dims    = d;
        base    = b;
        strides = '0;
        ranges  = '0;
        strides[0 +: 16]  = s0;
        strides[16 +: 16] = s1;
        strides[32 +: 16] = s2;
        ranges[0 +: 32]   = r0;
        ranges[32 +: 32]  = r1;
        ranges[64 +: 32]  = r2;
        iter    = it;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic test_reset();
        total_cnt++;
        if ({addr, valid, last, busy, done} !== 20'h0) begin
            $display("FAIL reset_outputs: got addr=%h v=%b l=%b b=%b d=%b, want all 0",
                     addr, valid, last, busy, done);
        end else pass_cnt++;
    endtask

    task automatic test_basic_3d();
        cfg(4'd3, 16'h0000, 16'd1, 16'd3, 16'd9, 32'd3, 32'd3, 32'd3, 32'd27);
        rdy = 1'b1;
        pulse_start();
        for (int k = 0; k < 27; k++) begin
            total_cnt++;
            if (valid !== 1'b1 || addr !== 16'(k) || last !== (k == 26) || busy !== 1'b1) begin
                $display("FAIL basic3d[%0d]: got addr=%h v=%b l=%b, want addr=%h v=1 l=%b",
                         k, addr, valid, last, 16'(k), (k == 26));
            end else pass_cnt++;
            start = (k == 10);  // ignored while running
            step();
            start = 1'b0;
        end
        total_cnt++;
        if (done !== 1'b1 || valid !== 1'b0) begin
            $display("FAIL basic3d_done: got done=%b v=%b, want done=1 v=0", done, valid);
        end else pass_cnt++;
        step();
        total_cnt++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            $display("FAIL basic3d_idle: got done=%b busy=%b, want 0 0", done, busy);
        end else pass_cnt++;
    endtask

    task automatic test_2d_base();
        logic [15:0] exp_tab [8];
        exp_tab = '{16'h100, 16'h102, 16'h104, 16'h106, 16'h110, 16'h112, 16'h114, 16'h116};
        cfg(4'd2, 16'h0100, 16'd2, 16'd16, 16'd0, 32'd4, 32'd2, 32'd0, 32'd8);
        rdy = 1'b1;
        pulse_start();
        for (int k = 0; k < 8; k++) begin
            total_cnt++;
            if (valid !== 1'b1 || addr !== exp_tab[k] || last !== (k == 7)) begin
                $display("FAIL 2d[%0d]: got addr=%h v=%b l=%b, want addr=%h l=%b",
                         k, addr, valid, last, exp_tab[k], (k == 7));
            end else pass_cnt++;
            step();
        end
        total_cnt++;
        if (done !== 1'b1) $display("FAIL 2d_done: got done=%b, want 1", done);
        else pass_cnt++;
        step();
    endtask

    task automatic test_circular_wrap();
        cfg(4'd1, 16'h0000, 16'd1, 16'd0, 16'd0, 32'd2, 32'd0, 32'd0, 32'd5);
        rdy = 1'b1;
        pulse_start();
        for (int k = 0; k < 5; k++) begin
            total_cnt++;
            if (valid !== 1'b1 || addr !== 16'(k % 2) || last !== (k == 4)) begin
                $display("FAIL wrap[%0d]: got addr=%h l=%b, want addr=%h l=%b",
                         k, addr, last, 16'(k % 2), (k == 4));
            end else pass_cnt++;
            step();
        end
        total_cnt++;
        if (done !== 1'b1) $display("FAIL wrap_done: got done=%b, want 1", done);
        else pass_cnt++;
        step();
    endtask

    task automatic test_backpressure();
        int k;
        int cyc;
        cfg(4'd3, 16'h0000, 16'd1, 16'd3, 16'd9, 32'd3, 32'd3, 32'd3, 32'd27);
        rdy = 1'b1;
        pulse_start();
        k   = 0;
        cyc = 0;
        while (k < 27 && cyc < 300) begin
            rdy    = 1'($urandom_range(0, 1));
            clk_en = !(cyc >= 5 && cyc <= 7);
            total_cnt++;
            if (valid !== 1'b1 || addr !== 16'(k) || last !== (k == 26)) begin
                $display("FAIL bp[cyc %0d]: got addr=%h v=%b l=%b, want addr=%h v=1 l=%b",
                         cyc, addr, valid, last, 16'(k), (k == 26));
            end else pass_cnt++;
            step();
            if (rdy && clk_en) k++;
            cyc++;
        end
        clk_en = 1'b1;
        rdy    = 1'b1;
        total_cnt++;
        if (k != 27) $display("FAIL bp_timeout: got %0d transfers, want 27", k);
        else pass_cnt++;
        total_cnt++;
        if (done !== 1'b1) $display("FAIL bp_done: got done=%b, want 1", done);
        else pass_cnt++;
        step();
    endtask

    task automatic test_flush();
        cfg(4'd3, 16'h0000, 16'd1, 16'd3, 16'd9, 32'd3, 32'd3, 32'd3, 32'd27);
        rdy = 1'b1;
        pulse_start();
        for (int k = 0; k < 4; k++) begin
            total_cnt++;
            if (addr !== 16'(k)) $display("FAIL flush_pre[%0d]: got addr=%h, want %h", k, addr, 16'(k));
            else pass_cnt++;
            step();
        end
        flush = 1'b1;
        step();
        flush = 1'b0;
        total_cnt++;
        if (valid !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin
            $display("FAIL flush_abort: got v=%b d=%b b=%b, want 0 0 0", valid, done, busy);
        end else pass_cnt++;
        step();
        total_cnt++;
        if (done !== 1'b0) $display("FAIL flush_nodone: got done=%b, want 0", done);
        else pass_cnt++;
        // flush beats a same-cycle start
        flush = 1'b1;
        start = 1'b1;
        step();
        flush = 1'b0;
        start = 1'b0;
        total_cnt++;
        if (valid !== 1'b0 || busy !== 1'b0) $display("FAIL flush_prio: got v=%b b=%b, want 0 0", valid, busy);
        else pass_cnt++;
        pulse_start();
        total_cnt++;
        if (valid !== 1'b1 || addr !== 16'h0000) $display("FAIL flush_restart: got v=%b addr=%h, want 1 0000", valid, addr);
        else pass_cnt++;
        step();
        total_cnt++;
        if (addr !== 16'h0001) $display("FAIL flush_restart2: got addr=%h, want 0001", addr);
        else pass_cnt++;
        flush = 1'b1;
        step();
        flush = 1'b0;
    endtask

    task automatic test_zero_iter();
        cfg(4'd3, 16'h0000, 16'd1, 16'd3, 16'd9, 32'd3, 32'd3, 32'd3, 32'd0);
        pulse_start();
        total_cnt++;
        if (valid !== 1'b0 || done !== 1'b1) $display("FAIL zero_iter: got v=%b d=%b, want 0 1", valid, done);
        else pass_cnt++;
        step();
        total_cnt++;
        if (valid !== 1'b0 || done !== 1'b0) $display("FAIL zero_iter_after: got v=%b d=%b, want 0 0", valid, done);
        else pass_cnt++;
    endtask

    task automatic test_single();
        cfg(4'd2, 16'h0ABC, 16'd5, 16'd7, 16'd0, 32'd4, 32'd4, 32'd0, 32'd1);
        rdy = 1'b0;
        pulse_start();
        total_cnt++;
        if (valid !== 1'b1 || last !== 1'b1 || addr !== 16'h0ABC) begin
            $display("FAIL single: got v=%b l=%b addr=%h, want 1 1 0abc", valid, last, addr);
        end else pass_cnt++;
        step();
        total_cnt++;
        if (valid !== 1'b1 || last !== 1'b1 || addr !== 16'h0ABC) begin
            $display("FAIL single_stall: got v=%b l=%b addr=%h, want 1 1 0abc", valid, last, addr);
        end else pass_cnt++;
        rdy = 1'b1;
        step();
        total_cnt++;
        if (done !== 1'b1 || valid !== 1'b0) $display("FAIL single_done: got d=%b v=%b, want 1 0", done, valid);
        else pass_cnt++;
        step();
    endtask

    task automatic test_reset_midrun();
        cfg(4'd3, 16'h0040, 16'd1, 16'd3, 16'd9, 32'd3, 32'd3, 32'd3, 32'd27);
        rdy = 1'b1;
        pulse_start();
        step();
        step();
        total_cnt++;
        if (addr !== 16'h0042) $display("FAIL rst_mid_pre: got addr=%h, want 0042", addr);
        else pass_cnt++;
        #2;
        rst_n = 1'b0;
        #1;
        total_cnt++;
        if ({addr, valid, last, busy, done} !== 20'h0) begin
            $display("FAIL rst_mid: got addr=%h v=%b l=%b b=%b d=%b, want all 0",
                     addr, valid, last, busy, done);
        end else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        step();
        total_cnt++;
        if (done !== 1'b0 || valid !== 1'b0) $display("FAIL rst_mid_nodone: got d=%b v=%b, want 0 0", done, valid);
        else pass_cnt++;
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        rst_n  = 1'b0;
        clk_en = 1'b1;
        flush  = 1'b0;
        start  = 1'b0;
        rdy    = 1'b0;
        cfg(4'd0, 16'h0, 16'd0, 16'd0, 16'd0, 32'd0, 32'd0, 32'd0, 32'd0);
        #12;
        test_reset();
        @(negedge clk);
        rst_n = 1'b1;
        step();
        test_basic_3d();
        test_2d_base();
        test_circular_wrap();
        test_backpressure();
        test_flush();
        test_zero_iter();
        test_single();
        test_reset_midrun();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

`default_nettype wire
